// File: rtl/z16_mmio_gpio_responder.sv
// MMIO responder for the Z16 load/store path: LED (0x7A), button status (0x7C), press counter (0x7E).
// Reads are combinational from i_addr; the button pin is synchronised, debounced and latched as sticky events.
module z16_mmio_gpio_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_wen,
    input  logic        i_ren,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_hit,
    input  logic        i_button_raw,
    output logic [5:0]  o_led,
    output logic        o_btn_event
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [15:0]    ADDR_LED = 16'h007A;
    localparam logic [15:0]    ADDR_BTN = 16'h007C;
    localparam logic [15:0]    ADDR_CNT = 16'h007E;

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_t;

    db_state_t      db_state;
    logic [CW-1:0]  db_cnt;
    logic           btn_in;
    logic           btn_meta;
    logic           btn_s;
    logic           level;
    logic           press_sticky;
    logic           rel_sticky;
    logic [15:0]    press_cnt;
    logic           press_commit;
    logic           release_commit;
    logic           sel_led;
    logic           sel_btn;
    logic           sel_cnt;
    logic           rd_clr;
    logic           unused_wdata;

    assign unused_wdata = ^i_wdata[15:6];
    assign btn_in       = BTN_ACTIVE_LOW ? ~i_button_raw : i_button_raw;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    // Commits happen on the edge where the (DEBOUNCE_CYCLES+1)-th equal sample is seen.
    assign press_commit   = (db_state == WAIT_HI) &&  btn_s && (db_cnt == CNT_DONE);
    assign release_commit = (db_state == WAIT_LO) && !btn_s && (db_cnt == CNT_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            db_state <= STABLE_LO;
            db_cnt   <= '0;
            level    <= 1'b0;
        end else begin
            case (db_state)
                STABLE_LO: begin
                    if (btn_s) begin
                        db_state <= WAIT_HI;
                        db_cnt   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!btn_s) begin
                        db_state <= STABLE_LO;
                        db_cnt   <= '0;
                    end else if (db_cnt == CNT_DONE) begin
                        db_state <= STABLE_HI;
                        db_cnt   <= '0;
                        level    <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!btn_s) begin
                        db_state <= WAIT_LO;
                        db_cnt   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (btn_s) begin
                        db_state <= STABLE_HI;
                        db_cnt   <= '0;
                    end else if (db_cnt == CNT_DONE) begin
                        db_state <= STABLE_LO;
                        db_cnt   <= '0;
                        level    <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end
                default: begin
                    db_state <= STABLE_LO;
                    db_cnt   <= '0;
                end
            endcase
        end
    end

    assign sel_led = (i_addr == ADDR_LED);
    assign sel_btn = (i_addr == ADDR_BTN);
    assign sel_cnt = (i_addr == ADDR_CNT);
    assign rd_clr  = i_ren && sel_btn;

    // A new event wins over a same-edge clear-on-read; a counter store wins over a same-edge press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_led        <= '0;
            press_sticky <= 1'b0;
            rel_sticky   <= 1'b0;
            press_cnt    <= '0;
        end else begin
            if (i_wen && sel_led)
                o_led <= i_wdata[5:0];

            if (press_commit)
                press_sticky <= 1'b1;
            else if (rd_clr)
                press_sticky <= 1'b0;

            if (release_commit)
                rel_sticky <= 1'b1;
            else if (rd_clr)
                rel_sticky <= 1'b0;

            if (i_wen && sel_cnt)
                press_cnt <= '0;
            else if (press_commit)
                press_cnt <= press_cnt + 16'd1;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (sel_led)
            o_rdata = {10'b0, o_led};
        else if (sel_btn)
            o_rdata = {13'b0, rel_sticky, press_sticky, level};
        else if (sel_cnt)
            o_rdata = press_cnt;
    end

    assign o_hit       = sel_led || sel_btn || sel_cnt;
    assign o_btn_event = press_sticky;

endmodule

// File: tb/tb_z16_mmio_gpio_responder.sv
// Bench for z16_mmio_gpio_responder: directed scenarios plus randomized traffic against a
// sliding-window debounce model (level follows D+1 equal synchronised samples).
module tb_z16_mmio_gpio_responder;

    localparam int D = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_addr;
    logic        i_wen;
    logic        i_ren;
    logic [15:0] i_wdata;
    logic [15:0] o_rdata;
    logic        o_hit;
    logic        i_button_raw;
    logic [5:0]  o_led;
    logic        o_btn_event;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_hist[D+3];
    logic [5:0]  m_led;
    bit          m_ps, m_rs, m_level;
    logic [15:0] m_cnt;

    z16_mmio_gpio_responder #(
        .DEBOUNCE_CYCLES (D),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_addr       (i_addr),
        .i_wen        (i_wen),
        .i_ren        (i_ren),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_hit        (o_hit),
        .i_button_raw (i_button_raw),
        .o_led        (o_led),
        .o_btn_event  (o_btn_event)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] m_rdata(input logic [15:0] a);
        case (a)
            16'h007A: return {10'b0, m_led};
            16'h007C: return {13'b0, m_rs, m_ps, m_level};
            16'h007E: return m_cnt;
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic logic m_hit(input logic [15:0] a);
        return (a == 16'h007A) || (a == 16'h007C) || (a == 16'h007E);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < D + 3; i++) m_hist[i] = 1'b0;
        m_led = '0; m_ps = 1'b0; m_rs = 1'b0; m_level = 1'b0; m_cnt = '0;
    endtask

    task automatic set_bus(input logic [15:0] a, input logic w, input logic r, input logic [15:0] d);
        i_addr = a; i_wen = w; i_ren = r; i_wdata = d;
    endtask

    // Apply the coming rising edge to the model, then advance the DUT past it.
    task automatic step();
        bit pressed, all_eq, v, press, rel, clr;
        pressed = ~i_button_raw;
        for (int i = D + 2; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = pressed;
        v = m_hist[2];
        all_eq = 1'b1;
        for (int i = 2; i <= D + 2; i++) if (m_hist[i] != v) all_eq = 1'b0;
        press = all_eq && v && !m_level;
        rel   = all_eq && !v && m_level;
        if (press) m_level = 1'b1;
        if (rel)   m_level = 1'b0;
        clr = i_ren && (i_addr == 16'h007C);
        if (press) m_ps = 1'b1; else if (clr) m_ps = 1'b0;
        if (rel)   m_rs = 1'b1; else if (clr) m_rs = 1'b0;
        if (i_wen && i_addr == 16'h007E) m_cnt = 16'h0000;
        else if (press) m_cnt = m_cnt + 16'd1;
        if (i_wen && i_addr == 16'h007A) m_led = i_wdata[5:0];
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] addrs[4];
        addrs[0] = 16'h007C; addrs[1] = 16'h007E; addrs[2] = 16'h007A; addrs[3] = 16'h0078;
        i_rst_n = 1'b0;
        i_button_raw = 1'b1;
        set_bus(16'h0000, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge i_clk);
        #1;
        m_reset();
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_bus(addrs[i], 1'b0, 1'b0, 16'h0000);
            #1;
            checks++;
            if (o_rdata !== 16'h0000) begin
                errors++; $display("FAIL reset_rdata addr=%h got=%h exp=0000", addrs[i], o_rdata);
            end
            checks++;
            if (o_hit !== (i < 3)) begin
                errors++; $display("FAIL reset_hit addr=%h got=%b exp=%b", addrs[i], o_hit, i < 3);
            end
        end
        checks++;
        if (o_led !== 6'h00 || o_btn_event !== 1'b0) begin
            errors++; $display("FAIL reset_outs led=%h evt=%b exp=00/0", o_led, o_btn_event);
        end
    endtask

    task automatic test_led();
        set_bus(16'h007A, 1'b1, 1'b0, 16'h00FF);
        step();
        set_bus(16'h007A, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_led !== 6'h3F || o_rdata !== 16'h003F) begin
            errors++; $display("FAIL led_store led=%h rdata=%h exp=3f/003f", o_led, o_rdata);
        end
        set_bus(16'h007C, 1'b1, 1'b0, 16'hFFFF);
        step();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0000 || o_led !== 6'h3F) begin
            errors++; $display("FAIL btn_store_ignored rdata=%h led=%h exp=0000/3f", o_rdata, o_led);
        end
    endtask

    task automatic test_press();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        i_button_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (o_rdata[0] !== (k >= 7)) begin
                errors++; $display("FAIL press_latency edge=%0d level=%b exp=%b", k, o_rdata[0], k >= 7);
            end
        end
        set_bus(16'h007C, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0003 || o_btn_event !== 1'b1) begin
            errors++; $display("FAIL press_read1 rdata=%h evt=%b exp=0003/1", o_rdata, o_btn_event);
        end
        step();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0001) begin
            errors++; $display("FAIL press_read2 rdata=%h exp=0001", o_rdata);
        end
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0001) begin
            errors++; $display("FAIL press_count rdata=%h exp=0001", o_rdata);
        end
    endtask

    task automatic test_release();
        i_button_raw = 1'b1;
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        repeat (20) step();
        checks++;
        if (o_rdata !== 16'h0004 || o_btn_event !== 1'b0) begin
            errors++; $display("FAIL release rdata=%h evt=%b exp=0004/0", o_rdata, o_btn_event);
        end
        set_bus(16'h007C, 1'b0, 1'b1, 16'h0000);
        step();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0000) begin
            errors++; $display("FAIL release_clear rdata=%h exp=0000", o_rdata);
        end
    endtask

    task automatic test_glitch();
        i_button_raw = 1'b0;
        repeat (3) step();
        i_button_raw = 1'b1;
        repeat (15) step();
        checks++;
        if (o_rdata !== 16'h0000) begin
            errors++; $display("FAIL glitch_btn rdata=%h exp=0000", o_rdata);
        end
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0001) begin
            errors++; $display("FAIL glitch_cnt rdata=%h exp=0001", o_rdata);
        end
    endtask

    task automatic test_read_collision();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        i_button_raw = 1'b0;
        repeat (6) step();
        set_bus(16'h007C, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0000) begin
            errors++; $display("FAIL collide_old rdata=%h exp=0000", o_rdata);
        end
        step();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0003 || o_btn_event !== 1'b1) begin
            errors++; $display("FAIL collide_after rdata=%h evt=%b exp=0003/1", o_rdata, o_btn_event);
        end
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0002) begin
            errors++; $display("FAIL collide_cnt rdata=%h exp=0002", o_rdata);
        end
        i_button_raw = 1'b1;
        repeat (12) step();
        set_bus(16'h007C, 1'b0, 1'b1, 16'h0000);
        step();
    endtask

    task automatic test_cnt_priority();
        set_bus(16'h0000, 1'b0, 1'b0, 16'h0000);
        i_button_raw = 1'b0;
        repeat (6) step();
        set_bus(16'h007E, 1'b1, 1'b0, 16'h1234);
        step();
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0000) begin
            errors++; $display("FAIL cnt_store_wins rdata=%h exp=0000", o_rdata);
        end
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0003) begin
            errors++; $display("FAIL cnt_store_btn rdata=%h exp=0003", o_rdata);
        end
        i_button_raw = 1'b1;
        repeat (12) step();
        set_bus(16'h007C, 1'b0, 1'b1, 16'h0000);
        step();
    endtask

    task automatic test_wrap();
        force dut.press_cnt = 16'hFFFF;
        #1;
        release dut.press_cnt;
        m_cnt = 16'hFFFF;
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preload rdata=%h exp=ffff", o_rdata);
        end
        i_button_raw = 1'b0;
        repeat (10) step();
        checks++;
        if (o_rdata !== 16'h0000) begin
            errors++; $display("FAIL wrap rdata=%h exp=0000", o_rdata);
        end
        i_button_raw = 1'b1;
        repeat (12) step();
        set_bus(16'h007C, 1'b0, 1'b1, 16'h0000);
        step();
    endtask

    task automatic test_reset_mid();
        set_bus(16'h0000, 1'b0, 1'b0, 16'h0000);
        i_button_raw = 1'b0;
        repeat (4) step();
        i_rst_n = 1'b0;
        #2;
        m_reset();
        i_button_raw = 1'b1;
        i_rst_n = 1'b1;
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        repeat (12) step();
        checks++;
        if (o_rdata !== 16'h0000 || o_btn_event !== 1'b0) begin
            errors++; $display("FAIL rst_mid_btn rdata=%h evt=%b exp=0000/0", o_rdata, o_btn_event);
        end
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (o_rdata !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_cnt rdata=%h exp=0000", o_rdata);
        end
    endtask

    task automatic test_random();
        int hold;
        logic [15:0] a;
        logic [15:0] addrs[4];
        addrs[0] = 16'h007A; addrs[1] = 16'h007C; addrs[2] = 16'h007E; addrs[3] = 16'h0078;
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            if (hold == 0) begin
                i_button_raw = $urandom_range(0, 1);
                hold = $urandom_range(1, 12);
            end
            hold--;
            a = ($urandom_range(0, 4) == 4) ? 16'($urandom) : addrs[$urandom_range(0, 3)];
            set_bus(a, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), 16'($urandom));
            #1;
            checks++;
            if (o_rdata !== m_rdata(a) || o_hit !== m_hit(a)) begin
                errors++;
                $display("FAIL rand_read n=%0d addr=%h rdata=%h hit=%b exp=%h/%b",
                         n, a, o_rdata, o_hit, m_rdata(a), m_hit(a));
            end
            step();
            checks++;
            if (o_led !== m_led || o_btn_event !== m_ps) begin
                errors++;
                $display("FAIL rand_outs n=%0d led=%h evt=%b exp=%h/%b", n, o_led, o_btn_event, m_led, m_ps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_led();
        test_press();
        test_release();
        test_glitch();
        test_read_collision();
        test_cnt_priority();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
